// File: rtl/rrf_alloc_ctrl.sv
// Rename-register tag allocator: grants 0/1/2 tags per cycle, reclaims them in order on commit, rolls back on flush.
// Tags and grants are combinational in the request cycle; a refused request (stall_o) is all-or-nothing and simply re-presented.
module rrf_alloc_ctrl #(
   parameter int RRF_NUM = 64,
   parameter int RRF_SEL = 6,
   parameter int REG_SEL = 5
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               req1_i,
   input  logic               req2_i,
   input  logic               dst_en1_i,
   input  logic               dst_en2_i,
   input  logic [REG_SEL-1:0] dst_num1_i,
   input  logic [REG_SEL-1:0] dst_num2_i,
   input  logic [1:0]         com_num_i,
   input  logic               flush_i,
   output logic               stall_o,
   output logic [RRF_SEL-1:0] tag1_o,
   output logic [RRF_SEL-1:0] tag2_o,
   output logic               setbusy1_en_o,
   output logic [REG_SEL-1:0] setbusy1_num_o,
   output logic [RRF_SEL-1:0] setbusy1_tag_o,
   output logic               setbusy2_en_o,
   output logic [REG_SEL-1:0] setbusy2_num_o,
   output logic [RRF_SEL-1:0] setbusy2_tag_o,
   output logic [RRF_SEL:0]   freenum_o,
   output logic               err_o
);

   localparam logic [RRF_SEL:0]   FULL = (RRF_SEL+1)'(RRF_NUM);
   localparam logic [RRF_SEL-1:0] ONE  = RRF_SEL'(1);

   logic [RRF_SEL-1:0] alloc_ptr;
   logic [RRF_SEL-1:0] com_ptr;
   logic [RRF_SEL:0]   freenum;
   logic               err;

   logic [1:0]         n;
   logic [1:0]         c;
   logic [1:0]         alloc_step;
   logic               grant;
   logic               over_commit;
   logic [RRF_SEL:0]   occ;
   logic [RRF_SEL:0]   com_ext;

   assign n       = {1'b0, req1_i} + {1'b0, req1_i & req2_i};
   assign occ     = FULL - freenum;
   assign com_ext = {{(RRF_SEL-1){1'b0}}, com_num_i};

   // Stall uses the registered count, so entries committed this cycle only help next cycle.
   assign stall_o    = flush_i | (freenum < {{(RRF_SEL-1){1'b0}}, n});
   assign grant      = ~stall_o & (n != 2'd0);
   assign alloc_step = grant ? n : 2'd0;

   always_comb begin
      c           = com_num_i;
      over_commit = (com_num_i == 2'd3);
      if (com_ext > occ) begin
         c           = occ[1:0];
         over_commit = 1'b1;
      end
   end

   assign tag1_o         = alloc_ptr;
   assign tag2_o         = alloc_ptr + ONE;
   assign setbusy1_en_o  = grant & req1_i & dst_en1_i;
   assign setbusy1_num_o = dst_num1_i;
   assign setbusy1_tag_o = tag1_o;
   assign setbusy2_en_o  = grant & req2_i & dst_en2_i;
   assign setbusy2_num_o = dst_num2_i;
   assign setbusy2_tag_o = tag2_o;
   assign freenum_o      = freenum;
   assign err_o          = err;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         alloc_ptr <= '0;
         com_ptr   <= '0;
         freenum   <= FULL;
         err       <= 1'b0;
      end else begin
         com_ptr <= com_ptr + {{(RRF_SEL-2){1'b0}}, c};
         if (over_commit)
            err <= 1'b1;
         if (flush_i) begin
            // Speculative allocations vanish; restart right after the last committed entry.
            alloc_ptr <= com_ptr + {{(RRF_SEL-2){1'b0}}, c};
            freenum   <= FULL;
         end else begin
            alloc_ptr <= alloc_ptr + {{(RRF_SEL-2){1'b0}}, alloc_step};
            freenum   <= freenum + {{(RRF_SEL-1){1'b0}}, c}
                                 - {{(RRF_SEL-1){1'b0}}, alloc_step};
         end
      end
   end

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Bench for rrf_alloc_ctrl: queue-based tag model feeds a scoreboard, a mid-cycle monitor checks every output.
module tb_rrf_alloc_ctrl;

   localparam int N = 64;

   logic       clk = 1'b0;
   logic       reset_i = 1'b0;
   logic       req1_i = 1'b0, req2_i = 1'b0, dst_en1_i = 1'b0, dst_en2_i = 1'b0;
   logic [4:0] dst_num1_i = '0, dst_num2_i = '0;
   logic [1:0] com_num_i = '0;
   logic       flush_i = 1'b0;
   logic       stall_o, setbusy1_en_o, setbusy2_en_o, err_o;
   logic [5:0] tag1_o, tag2_o, setbusy1_tag_o, setbusy2_tag_o;
   logic [4:0] setbusy1_num_o, setbusy2_num_o;
   logic [6:0] freenum_o;

   always #5 clk = ~clk;

   rrf_alloc_ctrl #(.RRF_NUM(64), .RRF_SEL(6), .REG_SEL(5)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .req1_i(req1_i), .req2_i(req2_i),
      .dst_en1_i(dst_en1_i), .dst_en2_i(dst_en2_i),
      .dst_num1_i(dst_num1_i), .dst_num2_i(dst_num2_i),
      .com_num_i(com_num_i), .flush_i(flush_i),
      .stall_o(stall_o), .tag1_o(tag1_o), .tag2_o(tag2_o),
      .setbusy1_en_o(setbusy1_en_o), .setbusy1_num_o(setbusy1_num_o), .setbusy1_tag_o(setbusy1_tag_o),
      .setbusy2_en_o(setbusy2_en_o), .setbusy2_num_o(setbusy2_num_o), .setbusy2_tag_o(setbusy2_tag_o),
      .freenum_o(freenum_o), .err_o(err_o)
   );

   typedef struct {
      int stall, tag1, tag2, sb1, sb2, n1, n2, fn, err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: the in-flight tags in age order, the next tag to hand out, and the next tag to retire.
   int   inflight[$];
   int   next_tag = 0;
   int   head_tag = 0;
   int   err_m = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
      end
   endfunction

   task automatic step(input bit rst, input bit r1, input bit r2, input bit e1, input bit e2,
                       input int d1, input int d2, input int com, input bit fl);
      exp_t e;
      int   free, n, c, occ;
      bit   stall, g;
      @(posedge clk);
      #1;
      reset_i    = !rst;
      req1_i     = r1;
      req2_i     = r2;
      dst_en1_i  = e1;
      dst_en2_i  = e2;
      dst_num1_i = 5'(d1);
      dst_num2_i = 5'(d2);
      com_num_i  = 2'(com);
      flush_i    = fl;
      if (rst) begin
         inflight.delete();
         next_tag = 0;
         head_tag = 0;
         err_m    = 0;
      end else begin
         free  = N - inflight.size();
         n     = r1 ? (r2 ? 2 : 1) : 0;
         stall = fl || (free < n);
         g     = !stall && n > 0;
         e.stall = stall;
         e.tag1  = next_tag;
         e.tag2  = (next_tag + 1) % N;
         e.sb1   = g && r1 && e1;
         e.sb2   = g && r2 && e2;
         e.n1    = d1;
         e.n2    = d2;
         e.fn    = free;
         e.err   = err_m;
         exp_q.push_back(e);
         occ = inflight.size();
         c   = (com > occ) ? occ : com;
         if (com == 3 || com > occ) err_m = 1;
         for (int i = 0; i < c; i++) void'(inflight.pop_front());
         head_tag = (head_tag + c) % N;
         if (fl) begin
            inflight.delete();
            next_tag = head_tag;
         end else if (g) begin
            for (int i = 0; i < n; i++) begin
               inflight.push_back(next_tag);
               next_tag = (next_tag + 1) % N;
            end
         end
      end
   endtask

   task automatic idle(input int com);
      step(0, 0, 0, 0, 0, 0, 0, com, 0);
   endtask

   task automatic pair(input int com);
      step(0, 1, 1, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 31), $urandom_range(0, 31), com, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", stall_o, e.stall);
            chk("tag1", tag1_o, e.tag1);
            chk("tag2", tag2_o, e.tag2);
            chk("sb1_en", setbusy1_en_o, e.sb1);
            chk("sb2_en", setbusy2_en_o, e.sb2);
            chk("sb1_num", setbusy1_num_o, e.n1);
            chk("sb2_num", setbusy2_num_o, e.n2);
            chk("sb1_tag", setbusy1_tag_o, e.tag1);
            chk("sb2_tag", setbusy2_tag_o, e.tag2);
            chk("freenum", freenum_o, e.fn);
            chk("err", err_o, e.err);
         end
      end
   end

   initial begin : stim
      int r, com;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 2, 1);
      idle(0);                                    // reset values
      for (int i = 0; i < 32; i++) pair(0);       // fill in pairs
      pair(2);                                    // full: stall, commit 2
      pair(0);                                    // tags 0,1 granted
      idle(1);                                    // freenum becomes 1
      pair(0);                                    // 1 free, 2 wanted: stall
      step(0, 1, 0, 1, 0, 7, 9, 0, 0);            // single request granted
      idle(0);

      // Wrap: alloc_ptr=63, com_ptr=10, conflicting destinations.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 31; i++) pair(0);
      step(0, 1, 0, 1, 0, 3, 0, 0, 0);
      for (int i = 0; i < 5; i++) idle(2);
      step(0, 1, 1, 1, 1, 5, 5, 0, 0);
      idle(0);

      // Flush with same-cycle commit and request.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) pair(0);
      step(0, 1, 0, 1, 0, 4, 0, 2, 1);
      idle(0);
      step(0, 1, 1, 1, 1, 1, 2, 0, 0);

      // Commit on empty, over-commit, sticky error cleared only by reset.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 3; i++) idle(0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) pair(0);
      idle(3);
      idle(0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(0);

      for (int i = 0; i < 1500; i++) begin
         r   = $urandom_range(0, 19);
         com = (r == 0) ? 3 : r % 3;
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 31), $urandom_range(0, 31),
              com, $urandom_range(0, 39) == 0);
      end
      idle(0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expected responses never checked, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
